// File: rtl/stage_pkg.sv
// Shared stage codes for the multicycle sequencer and the stage-enable decoder.
// Both sides import these constants so the 3-bit Stage encoding is defined once.
package stage_pkg;

  localparam int STAGE_W = 3;

  localparam logic [STAGE_W-1:0] STAGE_IDLE      = 3'd0;
  localparam logic [STAGE_W-1:0] STAGE_FETCH     = 3'd1;
  localparam logic [STAGE_W-1:0] STAGE_DECODE    = 3'd2;
  localparam logic [STAGE_W-1:0] STAGE_EXECUTE   = 3'd3;
  localparam logic [STAGE_W-1:0] STAGE_MEMORY    = 3'd4;
  localparam logic [STAGE_W-1:0] STAGE_WRITEBACK = 3'd5;
  localparam logic [STAGE_W-1:0] STAGE_HALT      = 3'd6;

  typedef enum logic [STAGE_W-1:0] {
    ST_IDLE      = STAGE_IDLE,
    ST_FETCH     = STAGE_FETCH,
    ST_DECODE    = STAGE_DECODE,
    ST_EXECUTE   = STAGE_EXECUTE,
    ST_MEMORY    = STAGE_MEMORY,
    ST_WRITEBACK = STAGE_WRITEBACK,
    ST_HALT      = STAGE_HALT,
    ST_ILLEGAL   = 3'd7
  } stage_e;

  // Sticky control state carried across instructions.
  typedef struct packed {
    logic halt_req;   // external Halt_Request seen, not yet serviced
    logic halt_pend;  // current instruction decoded as HALT
    logic step;       // running a single-step instruction from IDLE
  } latch_t;

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and the processor core.
// master drives run control and decode/memory status; slave is the sequencer.
interface stage_sequencer_if #(
  parameter int COUNT_W = 16
);

  logic                         Run;
  logic                         Step;
  logic                         Resume;
  logic                         Halt_Request;
  logic                         Mem_Ready;
  logic                         Is_NOP;
  logic                         Is_HALT;
  logic                         Mem_Access;
  logic [stage_pkg::STAGE_W-1:0] Stage;
  logic                         NOP_FLAG;
  logic                         Halted;
  logic                         Fault;
  logic [COUNT_W-1:0]           Instr_Count;

  modport master (
    output Run, Step, Resume, Halt_Request, Mem_Ready, Is_NOP, Is_HALT, Mem_Access,
    input  Stage, NOP_FLAG, Halted, Fault, Instr_Count
  );

  modport slave (
    input  Run, Step, Resume, Halt_Request, Mem_Ready, Is_NOP, Is_HALT, Mem_Access,
    output Stage, NOP_FLAG, Halted, Fault, Instr_Count
  );

endinterface

// File: rtl/stall_timer.sv
// Consecutive-stall counter for Fetch/Memory waits. Timeout is high during the
// stall cycle whose increment would bring the count to MAX_WAIT.
module stall_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic clr,
  input  logic inc,
  output logic Timeout
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every signal written in an always_comb is given a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: registers are updated only with non-blocking <= in always_ff; blocking = stays in always_comb.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Timeout = (count_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: walks Fetch..WriteBack one stage per cycle, stalls on
// memory readiness, and handles run, single-step, halt, resume and stall timeout.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int COUNT_W  = 16
) (
  input  logic                Clock,
  input  logic                Reset_n,
  stage_sequencer_if.slave    bus
);

  stage_e             stage_q, stage_d;
  logic               nop_q, nop_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;
  logic [COUNT_W-1:0] count_q, count_d;
  latch_t             lat_q, lat_d;

  logic stall;
  logic timeout;
  logic timer_clr;
  logic timer_inc;

  stall_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_stall_timer (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .clr     (timer_clr),
    .inc     (timer_inc),
    .Timeout (timeout)
  );

  always_comb begin
    stage_d = stage_q;
    nop_d   = nop_q;
    fault_d = fault_q;
    count_d = count_q;
    lat_d   = lat_q;
    stall   = 1'b0;

    // Halt requests are remembered everywhere except while already halted.
    if (stage_q != ST_HALT) begin
      lat_d.halt_req = lat_q.halt_req | bus.Halt_Request;
    end

    case (stage_q)
      ST_IDLE: begin
        if (lat_q.halt_req || bus.Halt_Request) begin
          stage_d = ST_HALT;
        end else if (bus.Run) begin
          stage_d = ST_FETCH;
        end else if (bus.Step) begin
          stage_d    = ST_FETCH;
          lat_d.step = 1'b1;
        end
      end

      ST_FETCH: begin
        if (bus.Mem_Ready) begin
          stage_d = ST_DECODE;
        end else begin
          stall = 1'b1;
          if (timeout) begin
            stage_d = ST_HALT;
            fault_d = 1'b1;
          end
        end
      end

      ST_DECODE: begin
        nop_d           = bus.Is_NOP;
        lat_d.halt_pend = bus.Is_HALT;
        stage_d         = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        stage_d = ST_MEMORY;
      end

      ST_MEMORY: begin
        // A NOP never touches memory, so its Mem_Access decode is ignored.
        if (bus.Mem_Access && !nop_q && !bus.Mem_Ready) begin
          stall = 1'b1;
          if (timeout) begin
            stage_d = ST_HALT;
            fault_d = 1'b1;
          end
        end else begin
          stage_d = ST_WRITEBACK;
        end
      end

      ST_WRITEBACK: begin
        count_d = count_q + 1'b1;
        nop_d   = 1'b0;
        if (lat_q.halt_req || bus.Halt_Request || lat_q.halt_pend) begin
          stage_d = ST_HALT;
        end else if (lat_q.step) begin
          stage_d    = ST_IDLE;
          lat_d.step = 1'b0;
        end else if (bus.Run) begin
          stage_d = ST_FETCH;
        end else begin
          stage_d = ST_IDLE;
        end
      end

      ST_HALT: begin
        if (bus.Resume) begin
          stage_d         = ST_FETCH;
          fault_d         = 1'b0;
          lat_d.halt_req  = 1'b0;
          lat_d.halt_pend = 1'b0;
        end
      end

      default: begin
        stage_d = ST_IDLE;
        nop_d   = 1'b0;
        lat_d   = '0;
      end
    endcase

    halted_d  = (stage_d == ST_HALT);
    timer_inc = stall & ~timeout;
    timer_clr = ~stall | timeout;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      stage_q  <= ST_IDLE;
      nop_q    <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= '0;
      lat_q    <= '0;
    end else begin
      stage_q  <= stage_d;
      nop_q    <= nop_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
      lat_q    <= lat_d;
    end
  end

  assign bus.Stage       = stage_q;
  assign bus.NOP_FLAG    = nop_q;
  assign bus.Halted      = halted_q;
  assign bus.Fault       = fault_q;
  assign bus.Instr_Count = count_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Table-driven bench for stage_sequencer: each vector is one clock of inputs plus
// the outputs expected after that edge; a second small-counter instance checks wrap.
module tb_stage_sequencer;

  import stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_w_n;

  stage_sequencer_if #(.COUNT_W(16)) bus ();
  stage_sequencer_if #(.COUNT_W(3))  bus_w ();

  stage_sequencer #(.MAX_WAIT(15), .COUNT_W(16)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  stage_sequencer #(.MAX_WAIT(4), .COUNT_W(3)) dut_w (
    .Clock   (clk),
    .Reset_n (rst_w_n),
    .bus     (bus_w)
  );

  // Stimulus bits: {rst_n, Run, Step, Resume, Halt_Request, Mem_Ready, Is_NOP, Is_HALT, Mem_Access}
  localparam logic [8:0] N   = 9'h100;
  localparam logic [8:0] RUN = 9'h080;
  localparam logic [8:0] STP = 9'h040;
  localparam logic [8:0] RES = 9'h020;
  localparam logic [8:0] HRQ = 9'h010;
  localparam logic [8:0] RDY = 9'h008;
  localparam logic [8:0] NOP = 9'h004;
  localparam logic [8:0] HLT = 9'h002;
  localparam logic [8:0] ACC = 9'h001;

  typedef struct {
    logic [8:0]  stim;
    logic [2:0]  stage;
    logic        nopf;
    logic        halted;
    logic        fault;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic [2:0]  stage;
    logic        nopf;
    logic        halted;
    logic        fault;
    logic [15:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic [8:0] stim, input logic [2:0] st,
                              input logic nf, input logic h, input logic f, input int c);
    vec_t v;
    v.stim   = stim;
    v.stage  = st;
    v.nopf   = nf;
    v.halted = h;
    v.fault  = f;
    v.cnt    = 16'(c);
    vecs.push_back(v);
  endfunction

  task automatic compare_main();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d stage", e.idx),  32'(bus.Stage),       32'(e.stage));
      check($sformatf("v%0d nop", e.idx),    32'(bus.NOP_FLAG),    32'(e.nopf));
      check($sformatf("v%0d halted", e.idx), 32'(bus.Halted),      32'(e.halted));
      check($sformatf("v%0d fault", e.idx),  32'(bus.Fault),       32'(e.fault));
      check($sformatf("v%0d count", e.idx),  32'(bus.Instr_Count), 32'(e.cnt));
    end
  endtask

  task automatic compare_wrap(input int edge_n);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL wrap scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check($sformatf("wrap e%0d stage", edge_n), 32'(bus_w.Stage),       32'(e.stage));
      check($sformatf("wrap e%0d count", edge_n), 32'(bus_w.Instr_Count), 32'(e.cnt));
    end
  endtask

  initial begin
    // Reset
    add(9'h000, 3'd0, 0, 0, 0, 0);
    add(9'h000, 3'd0, 0, 0, 0, 0);
    // Continuous run, three unstalled instructions
    for (int k = 0; k < 3; k++) begin
      add(N|RUN|RDY, 3'd1, 0, 0, 0, k);
      add(N|RUN|RDY, 3'd2, 0, 0, 0, k);
      add(N|RUN|RDY, 3'd3, 0, 0, 0, k);
      add(N|RUN|RDY, 3'd4, 0, 0, 0, k);
      add(N|RUN|RDY, 3'd5, 0, 0, 0, k);
    end
    add(N|RUN|RDY, 3'd1, 0, 0, 0, 3);
    // Fetch stall of four cycles; a stray Resume is dropped
    add(N|RUN,     3'd1, 0, 0, 0, 3);
    add(N|RUN|RES, 3'd1, 0, 0, 0, 3);
    add(N|RUN,     3'd1, 0, 0, 0, 3);
    add(N|RUN,     3'd1, 0, 0, 0, 3);
    add(N|RUN|RDY, 3'd2, 0, 0, 0, 3);
    // NOP with Mem_Access: no Memory stall, flag clears at next Fetch
    add(N|RUN|NOP|ACC, 3'd3, 1, 0, 0, 3);
    add(N|RUN|ACC,     3'd4, 1, 0, 0, 3);
    add(N|RUN|ACC,     3'd5, 1, 0, 0, 3);
    add(N|RUN|ACC,     3'd1, 0, 0, 0, 4);
    // Load that never completes: 15th unready cycle trips the fault
    add(N|RUN|RDY, 3'd2, 0, 0, 0, 4);
    add(N|RUN|ACC, 3'd3, 0, 0, 0, 4);
    add(N|RUN|ACC, 3'd4, 0, 0, 0, 4);
    for (int k = 0; k < 14; k++) add(N|RUN|ACC, 3'd4, 0, 0, 0, 4);
    add(N|RUN|ACC,     3'd6, 0, 1, 1, 4);
    add(N|RUN|STP|RDY, 3'd6, 0, 1, 1, 4);
    add(N|RES,         3'd1, 0, 0, 0, 4);
    // Finish to IDLE, then single-step; step latch wins over Run at WriteBack
    add(N|RDY, 3'd2, 0, 0, 0, 4);
    add(N,     3'd3, 0, 0, 0, 4);
    add(N,     3'd4, 0, 0, 0, 4);
    add(N,     3'd5, 0, 0, 0, 4);
    add(N,     3'd0, 0, 0, 0, 5);
    add(N|RDY, 3'd0, 0, 0, 0, 5);
    add(N|STP, 3'd1, 0, 0, 0, 5);
    add(N|RDY, 3'd2, 0, 0, 0, 5);
    add(N,     3'd3, 0, 0, 0, 5);
    add(N,     3'd4, 0, 0, 0, 5);
    add(N,     3'd5, 0, 0, 0, 5);
    add(N|RUN, 3'd0, 0, 0, 0, 6);
    add(N,     3'd0, 0, 0, 0, 6);
    // Halt_Request pulsed in Execute is serviced after WriteBack
    add(N|RUN,     3'd1, 0, 0, 0, 6);
    add(N|RUN|RDY, 3'd2, 0, 0, 0, 6);
    add(N|RUN,     3'd3, 0, 0, 0, 6);
    add(N|RUN|HRQ, 3'd4, 0, 0, 0, 6);
    add(N|RUN,     3'd5, 0, 0, 0, 6);
    add(N|RUN,     3'd6, 0, 1, 0, 7);
    add(N|RUN,     3'd6, 0, 1, 0, 7);
    add(N|RES,     3'd1, 0, 0, 0, 7);
    // Decoded HALT instruction
    add(N|RDY,     3'd2, 0, 0, 0, 7);
    add(N|HLT,     3'd3, 0, 0, 0, 7);
    add(N,         3'd4, 0, 0, 0, 7);
    add(N,         3'd5, 0, 0, 0, 7);
    add(N|RUN,     3'd6, 0, 1, 0, 8);
    add(N|RES,     3'd1, 0, 0, 0, 8);
    // Halt_Request arriving in the WriteBack cycle itself
    add(N|RDY,     3'd2, 0, 0, 0, 8);
    add(N,         3'd3, 0, 0, 0, 8);
    add(N,         3'd4, 0, 0, 0, 8);
    add(N,         3'd5, 0, 0, 0, 8);
    add(N|RUN|HRQ, 3'd6, 0, 1, 0, 9);
    add(N|RES,     3'd1, 0, 0, 0, 9);
    // Halt_Request in IDLE beats Run
    add(N|RDY,     3'd2, 0, 0, 0, 9);
    add(N,         3'd3, 0, 0, 0, 9);
    add(N,         3'd4, 0, 0, 0, 9);
    add(N,         3'd5, 0, 0, 0, 9);
    add(N,         3'd0, 0, 0, 0, 10);
    add(N|RUN|HRQ, 3'd6, 0, 1, 0, 10);
    add(N|RES,     3'd1, 0, 0, 0, 10);
    // Fetch timeout
    for (int k = 0; k < 14; k++) add(N, 3'd1, 0, 0, 0, 10);
    add(N,         3'd6, 0, 1, 1, 10);
    add(N|RES,     3'd1, 0, 0, 0, 10);
    // Reset during Memory abandons the instruction and clears everything
    add(N|RDY,     3'd2, 0, 0, 0, 10);
    add(N,         3'd3, 0, 0, 0, 10);
    add(N,         3'd4, 0, 0, 0, 10);
    add(RUN|RDY,   3'd0, 0, 0, 0, 0);
    add(N,         3'd0, 0, 0, 0, 0);

    // Wrap instance idles in reset until its own phase
    rst_w_n            = 1'b0;
    bus_w.Run          = 1'b1;
    bus_w.Step         = 1'b0;
    bus_w.Resume       = 1'b0;
    bus_w.Halt_Request = 1'b0;
    bus_w.Mem_Ready    = 1'b1;
    bus_w.Is_NOP       = 1'b0;
    bus_w.Is_HALT      = 1'b0;
    bus_w.Mem_Access   = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      rst_n            = vecs[i].stim[8];
      bus.Run          = vecs[i].stim[7];
      bus.Step         = vecs[i].stim[6];
      bus.Resume       = vecs[i].stim[5];
      bus.Halt_Request = vecs[i].stim[4];
      bus.Mem_Ready    = vecs[i].stim[3];
      bus.Is_NOP       = vecs[i].stim[2];
      bus.Is_HALT      = vecs[i].stim[1];
      bus.Mem_Access   = vecs[i].stim[0];
      e.idx    = i;
      e.stage  = vecs[i].stage;
      e.nopf   = vecs[i].nopf;
      e.halted = vecs[i].halted;
      e.fault  = vecs[i].fault;
      e.cnt    = vecs[i].cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_main();
    end

    // Counter wrap: 3-bit Instr_Count, continuous unstalled run from reset
    rst_w_n = 1'b0;
    @(posedge clk);
    #1;
    check("wrap reset stage", 32'(bus_w.Stage), 32'd0);
    check("wrap reset count", 32'(bus_w.Instr_Count), 32'd0);
    rst_w_n = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      exp_t e;
      e.idx    = n;
      e.stage  = 3'(((n - 1) % 5) + 1);
      e.nopf   = 1'b0;
      e.halted = 1'b0;
      e.fault  = 1'b0;
      e.cnt    = 16'(((n - 1) / 5) % 8);
      sb.push_back(e);
      @(posedge clk);
      #1;
      compare_wrap(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multicycle stage sequencer for the CSC317 processor. It generates the 3-bit `Stage` code (Fetch=1 … WriteBack=5) and `NOP_FLAG` that the stage-enable decoder consumes. It advances one stage per cycle, stalls Fetch and Memory on a memory-ready handshake, and handles run, single-step, halt and timeout fault.

## Interface
Parameters:
- `MAX_WAIT`, 15: maximum consecutive stall cycles in Fetch or Memory before the fault trips.
- `COUNT_W`, 16: width of the retired-instruction counter.

Ports:
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `Reset_n`  in  1  synchronous, active-low reset.
- `Run`  in  1  level; permits continuous execution.
- `Step`  in  1  one-cycle pulse; in IDLE, executes exactly one instruction, then returns to IDLE.
- `Resume`  in  1  one-cycle pulse; leaves HALT.
- `Halt_Request`  in  1  pulse; sticky until serviced.
- `Mem_Ready`  in  1  memory completes the current read/write this cycle.
- `Is_NOP`  in  1  decoded from the IR; valid during Decode.
- `Is_HALT`  in  1  decoded from the IR; valid during Decode.
- `Mem_Access`  in  1  current instruction uses memory in the Memory stage (`Memory_Z_RM_WM_RF` ≠ 0).
- `Stage`  out  3  registered stage code: 0 IDLE, 1 Fetch, 2 Decode, 3 Execute, 4 Memory, 5 WriteBack, 6 HALT.
- `NOP_FLAG`  out  1  registered; current instruction is a NOP.
- `Halted`  out  1  high while `Stage` = 6.
- `Fault`  out  1  sticky; set by the stall timeout.
- `Instr_Count`  out  COUNT_W  retired instructions; wraps.

## Operation
- Reset (`Reset_n`=0 at an edge) sets: `Stage`=0, `NOP_FLAG`=0, `Halted`=0, `Fault`=0, `Instr_Count`=0. It also clears the halt latch, the step latch, the HALT-pending flag and the wait counter. Reset mid-instruction abandons the instruction with no count.
- IDLE(0):
  - `Run`=1 → 1.
  - Otherwise, `Step`=1 → 1 with the step latch set.
  - Otherwise stay in IDLE.
- Fetch(1):
  - `Mem_Ready`=1 → 2, wait counter cleared.
  - Otherwise stay and increment the wait counter.
  - Counter reaching `MAX_WAIT` with `Mem_Ready`=0 → HALT with `Fault`=1.
- Decode(2): latch `NOP_FLAG` ← `Is_NOP` and the HALT-pending flag ← `Is_HALT`; → 3.
- Execute(3): → 4 unconditionally.
- Memory(4):
  - If `Mem_Access`=1 and `NOP_FLAG`=0: wait on `Mem_Ready` with the same counter and timeout rule as Fetch.
  - Otherwise → 5 immediately; `Mem_Ready` is ignored.
- WriteBack(5): `Instr_Count` increments (modular wrap). Next state, in priority order:
  1. Halt latch or HALT-pending flag set → 6.
  2. Step latch set → 0, step latch cleared.
  3. `Run`=1 → 1.
  4. Otherwise → 0.
- Leaving WriteBack clears `NOP_FLAG`.
- HALT(6):
  - `Resume`=1 → 1; clears `Halted`, `Fault`, the halt latch and the HALT-pending flag.
  - Otherwise stay; `Run`/`Step` are ignored.
- `Halt_Request` latching:
  - Latched in any state except HALT.
  - A request arriving in the same cycle as WriteBack is serviced at that boundary.
  - A request in IDLE → 6 on the next edge.
- Illegal `Stage` code 7 → 0 next edge; `NOP_FLAG`, latches and wait counter cleared; `Instr_Count` is not touched.
- `Step` or `Resume` outside its owning state is dropped.

## Timing
- All outputs are registered; the downstream enable decoder is combinational on `Stage`/`NOP_FLAG`, so enables align with the stage cycle.
- Unstalled instruction latency is 5 cycles. In continuous Run, stage sequence is 1,2,3,4,5,1,… with no idle bubble.
- Each wait cycle adds exactly one cycle. A `Mem_Ready` seen at edge N moves `Stage` at edge N.
- Timeout: with `MAX_WAIT`=15, the 15th consecutive unready cycle in a stage → `Stage`=6 and `Fault`=1 on the following edge.
- `Instr_Count` updates on the edge leaving WriteBack.
- `Halted` asserts on the same edge `Stage` becomes 6.

## Structure
- Shared package `stage_pkg` holds:
  - `localparam`s `STAGE_IDLE`=0, `STAGE_FETCH`=1, `STAGE_DECODE`=2, `STAGE_EXECUTE`=3, `STAGE_MEMORY`=4, `STAGE_WRITEBACK`=5, `STAGE_HALT`=6.
  - Stage width of 3. The stage-enable decoder imports the same constants.
- One sub-module, `stall_timer`: a clear/increment counter of width $clog2(`MAX_WAIT`+1) with a `Timeout` output. Everything else stays in a single FSM module.

## Test plan
- Reset, `Run`=1, `Mem_Ready`=1 steady → `Stage` 0,1,2,3,4,5,1,…; after 3 instructions `Instr_Count`=3.
- Fetch stall: `Mem_Ready`=0 for 4 cycles in Fetch → `Stage` stays 1 for 5 cycles total, then 2.
- Load with `Mem_Access`=1 and `Mem_Ready`=0 for 15 cycles → `Stage`=6, `Fault`=1, `Halted`=1. `Resume` pulse → `Stage`=1, `Fault`=0.
- `Is_NOP`=1 in Decode with `Mem_Access`=1 and `Mem_Ready`=0 → `NOP_FLAG`=1 through Stage 5; Memory is not stalled; `NOP_FLAG`=0 at the next Fetch.
- `Run`=0, `Step` pulse in IDLE → one 5-stage pass, back to 0, `Instr_Count`+1. `Halt_Request` pulsed in Execute → after WriteBack, `Stage`=6.
- `Reset_n`=0 during Stage 4 → next edge all outputs are 0. With `Instr_Count` at 16'hFFFF, one retire → 0.
